// File: rtl/entropy_requester.sv
// entropy_requester: fetches N TRNG bytes, each on a fresh valid edge, and streams them out
// on a valid/ready port, aborting a run if any single byte takes too long.
module entropy_requester #(
    parameter int VEC_W          = 8,
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SINGLE_SHOT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_bytes,
    output logic             trng_req,
    input  logic [VEC_W-1:0] trng_vector,
    input  logic             trng_vector_valid,
    output logic [VEC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] bytes_left
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic             valid_q, capture;
    logic             req_n, out_valid_n, done_n, timeout_n;
    logic [VEC_W-1:0] out_data_n;
    logic [CNT_W-1:0] bytes_left_n;
    // only a rising edge counts, so a level left high by the TRNG is never re-read
    assign capture = trng_vector_valid & ~valid_q;
    assign busy    = state != S_IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            valid_q    <= 1'b0;
            trng_req   <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            bytes_left <= '0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            valid_q    <= trng_vector_valid;
            trng_req   <= req_n;
            out_data   <= out_data_n;
            out_valid  <= out_valid_n;
            done       <= done_n;
            timeout    <= timeout_n;
            bytes_left <= bytes_left_n;
        end
    end
    always_comb begin
        state_n      = state;
        timer_n      = timer;
        req_n        = trng_req;
        out_data_n   = out_data;
        out_valid_n  = out_valid;
        done_n       = 1'b0;
        timeout_n    = timeout;
        bytes_left_n = bytes_left;
        case (state)
            S_IDLE: begin
                if (start && num_bytes != '0) begin
                    bytes_left_n = num_bytes;
                    timeout_n    = 1'b0;
                    state_n      = S_REQ;
                end
            end
            S_REQ: begin
                req_n   = 1'b1;
                timer_n = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                req_n = (SINGLE_SHOT == 0);
                // capture is tested first so it wins over a coinciding timeout
                if (capture) begin
                    out_data_n  = trng_vector;
                    out_valid_n = 1'b1;
                    req_n       = 1'b0;
                    state_n     = S_HOLD;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_n    = 1'b1;
                    req_n        = 1'b0;
                    bytes_left_n = '0;
                    state_n      = S_IDLE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    bytes_left_n = bytes_left - CNT_W'(1);
                    out_valid_n  = 1'b0;
                    done_n       = bytes_left == CNT_W'(1);
                    state_n      = bytes_left == CNT_W'(1) ? S_IDLE : S_REQ;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_entropy_requester.sv
// tb_entropy_requester: directed runs against a transaction-level model, checked every cycle,
// on a held-request instance and a single-shot instance fed the same stimulus.
module tb_entropy_requester;
    localparam int VW = 8;
    localparam int CW = 4;
    localparam int TO = 16;
    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, tvv = 1'b0, out_ready = 1'b0;
    logic [CW-1:0] num_bytes = '0;
    logic [VW-1:0] trng_vector = '0;
    logic          req0, req1, ov0, ov1, busy0, busy1, done0, done1, to0, to1;
    logic [VW-1:0] od0, od1;
    logic [CW-1:0] bl0, bl1;
    int n_cmp = 0, n_bad = 0;
    entropy_requester #(.VEC_W(VW), .CNT_W(CW), .TIMEOUT_CYCLES(TO), .SINGLE_SHOT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .num_bytes(num_bytes), .trng_req(req0),
        .trng_vector(trng_vector), .trng_vector_valid(tvv), .out_data(od0), .out_valid(ov0),
        .out_ready(out_ready), .busy(busy0), .done(done0), .timeout(to0), .bytes_left(bl0));
    entropy_requester #(.VEC_W(VW), .CNT_W(CW), .TIMEOUT_CYCLES(TO), .SINGLE_SHOT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .num_bytes(num_bytes), .trng_req(req1),
        .trng_vector(trng_vector), .trng_vector_valid(tvv), .out_data(od1), .out_valid(ov1),
        .out_ready(out_ready), .busy(busy1), .done(done1), .timeout(to1), .bytes_left(bl1));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // model: a run is a count of bytes still owed; age tracks the current fetch
    // (-1 none, 0 request cycle, k = k-th cycle spent waiting for the TRNG)
    logic          m_busy = 0, m_req0 = 0, m_req1 = 0, m_ov = 0, m_done = 0, m_to = 0, m_vq = 0, rise;
    logic [VW-1:0] m_data = '0;
    int            m_left = 0, m_age = -1;
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            {m_busy, m_req0, m_req1, m_ov, m_done, m_to, m_vq} = '0;
            m_data = '0;
            m_left = 0;
            m_age  = -1;
        end else begin
            rise   = tvv & ~m_vq;
            m_done = 0;
            if (!m_busy) begin
                if (start && num_bytes != 0) begin
                    m_busy = 1; m_left = num_bytes; m_to = 0; m_age = 0;
                end
            end else if (m_age == 0) begin
                m_req0 = 1; m_req1 = 1; m_age = 1;
            end else if (m_age > 0) begin
                m_req1 = 0;
                if (rise) begin
                    m_data = trng_vector; m_ov = 1; m_req0 = 0; m_age = -1;
                end else if (m_age == TO) begin
                    m_to = 1; m_req0 = 0; m_busy = 0; m_left = 0; m_age = -1;
                end else m_age++;
            end else if (out_ready) begin
                m_ov = 0;
                m_left--;
                if (m_left == 0) begin m_done = 1; m_busy = 0; end
                else m_age = 0;
            end
            m_vq = tvv;
        end
    end
    initial forever begin
        @(negedge clk);
        chk("out_valid", ov0, m_ov);
        chk("out_data", od0, m_data);
        chk("busy", busy0, m_busy);
        chk("done", done0, m_done);
        chk("timeout", to0, m_to);
        chk("bytes_left", bl0, m_left);
        chk("trng_req", req0, m_req0);
        chk("trng_req_ss", req1, m_req1);
        chk("out_valid_ss", ov1, m_ov);
    end
    // event log used by the hand-computed checks
    logic [VW-1:0] beats[$];
    int rises = 0, dones = 0, ss_w = 0, ss_pulses = 0;
    logic req0_q = 0;
    initial forever begin
        @(negedge clk);
        if (ov0 && out_ready) beats.push_back(od0);
        if (req0 && !req0_q) rises++;
        req0_q = req0;
        if (done0) dones++;
        if (req1) ss_w++;
        else if (ss_w != 0) begin
            ss_pulses++;
            chk("ss req width", ss_w, 1);
            ss_w = 0;
        end
    end
    task automatic serve(input logic [VW-1:0] b, input int dly);
        int n = 0;
        while (!req0 && n < 100) begin tick(); n++; end
        chk("req seen", req0, 1);
        repeat (dly) tick();
        trng_vector = b;
        tvv = 1;
        tick();
        tvv = 0;
    endtask
    task automatic wait_idle();
        int n = 0;
        while (busy0 && n < 300) begin tick(); n++; end
        chk("run ended", busy0, 0);
        tick();
    endtask
    task automatic go(input int nb);
        num_bytes = CW'(nb);
        start = 1;
        tick();
        start = 0;
    endtask
    initial begin
        int n;
        repeat (2) tick();
        chk("reset out_valid", ov0, 0);
        chk("reset out_data", od0, 0);
        chk("reset trng_req", req0, 0);
        chk("reset busy", busy0, 0);
        chk("reset bytes_left", bl0, 0);
        rst = 0;
        tick();
        // reset asserted while waiting on the TRNG
        go(2);
        tick();
        chk("t1 in wait req", req0, 1);
        #2 rst = 1;
        #1;
        chk("t1 rst req", req0, 0);
        chk("t1 rst busy", busy0, 0);
        chk("t1 rst bytes_left", bl0, 0);
        chk("t1 rst timeout", to0, 0);
        tick();
        rst = 0;
        tick();
        chk("t1 no done", dones, 0);
        // three bytes, ready always high
        out_ready = 1;
        beats.delete();
        rises = 0;
        go(3);
        chk("t2 bytes_left", bl0, 3);
        serve(8'hA5, 10);
        serve(8'h3C, 10);
        serve(8'hFF, 10);
        wait_idle();
        chk("t2 beat count", beats.size(), 3);
        if (beats.size() == 3) begin
            chk("t2 beat0", beats[0], 8'hA5);
            chk("t2 beat1", beats[1], 8'h3C);
            chk("t2 beat2", beats[2], 8'hFF);
        end
        chk("t2 req count", rises, 3);
        chk("t2 done count", dones, 1);
        chk("t2 bytes_left end", bl0, 0);
        // backpressure with TRNG noise during hold
        out_ready = 0;
        beats.delete();
        go(2);
        serve(8'hA5, 3);
        for (int i = 0; i < 5; i++) begin
            trng_vector = 8'h77;
            tvv = (i % 2) == 0;
            tick();
            chk("t3 hold data", od0, 8'hA5);
            chk("t3 hold req", req0, 0);
            chk("t3 hold bytes_left", bl0, 2);
        end
        tvv = 0;
        tick();
        out_ready = 1;
        serve(8'h3C, 2);
        wait_idle();
        chk("t3 beat count", beats.size(), 2);
        if (beats.size() == 2) begin
            chk("t3 beat0", beats[0], 8'hA5);
            chk("t3 beat1", beats[1], 8'h3C);
        end
        // silent TRNG
        beats.delete();
        go(1);
        tick();
        n = 0;
        while (!to0 && n < 40) begin tick(); n++; end
        chk("t4 wait cycles", n, 16);
        chk("t4 busy", busy0, 0);
        chk("t4 bytes_left", bl0, 0);
        chk("t4 no beats", beats.size(), 0);
        go(1);
        chk("t4 timeout cleared", to0, 0);
        serve(8'h5A, 1);
        wait_idle();
        chk("t4 timeout stays clear", to0, 0);
        // valid already high before the run
        beats.delete();
        tvv = 1;
        repeat (2) tick();
        go(1);
        repeat (6) tick();
        chk("t5 no capture", ov0, 0);
        chk("t5 still waiting", req0, 1);
        tvv = 0;
        tick();
        trng_vector = 8'hC3;
        tvv = 1;
        tick();
        chk("t5 captured", ov0, 1);
        chk("t5 data", od0, 8'hC3);
        tvv = 0;
        wait_idle();
        chk("t5 beat count", beats.size(), 1);
        // zero-length start, start while busy, single-shot request width
        rises = 0;
        ss_pulses = 0;
        num_bytes = 0;
        start = 1;
        repeat (3) tick();
        start = 0;
        chk("t6 zero busy", busy0, 0);
        chk("t6 zero no req", rises, 0);
        beats.delete();
        go(2);
        num_bytes = 5;
        tick();
        start = 1;
        repeat (2) tick();
        start = 0;
        chk("t6 busy ignore bytes_left", bl0, 2);
        serve(8'h11, 2);
        serve(8'h22, 2);
        wait_idle();
        chk("t6 beat count", beats.size(), 2);
        if (beats.size() == 2) begin
            chk("t6 beat0", beats[0], 8'h11);
            chk("t6 beat1", beats[1], 8'h22);
        end
        chk("t6 ss pulses", ss_pulses, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
        $fatal(1);
    end
endmodule
